seg7_serial_rx: RTL



---
 rtl/seg7_serial_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg7_serial_rx.sv
// seg7_serial_rx: receiver/decoder for the serial 7-segment link (SEGLED_CLK/DO/PEN/CLR)
// Ports: clk, rst (async, active-high); seg_clk/seg_do/seg_pen/seg_clr serial inputs;
//   frame = last good raw frame, digits/digit_valid = decoded hex digits and glyph-legal flags,
//   frame_valid = one-cycle pulse when the outputs update, frame_err = one-cycle pulse on bad count/timeout.
// Optional: define SEG7_RX_SCORE_EN to add score_bin (d2*100+d1*10+d0) and score_ok.
module seg7_serial_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_do,
  input  logic                  seg_pen,
  input  logic                  seg_clr,
  output logic [FRAME_BITS-1:0] frame,
  output logic [31:0]           digits,
  output logic [7:0]            digit_valid,
  output logic                  frame_valid,
  output logic                  frame_err
`ifdef SEG7_RX_SCORE_EN
  ,
  output logic [10:0]           score_bin,
  output logic                  score_ok
`endif
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DECODE = 2'd2;
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic [3:0] cur;
  logic [1:0] prev;
  logic clk_rise, pen_rise;
  logic [1:0] state;
  logic [FRAME_BITS-1:0] sr, n_sr, stage;
  logic [CW-1:0] cnt, n_cnt;
  logic [TW-1:0] tcnt;
  logic [2:0] idx;
  logic [27:0] dig_acc;
  logic [6:0] val_acc;
  logic [4:0] g;
  logic [31:0] nd;
  logic [7:0] nv;
  function automatic logic [4:0] glyph(input logic [6:0] s);
    case (s)
      7'h3F: glyph = 5'h10;
      7'h06: glyph = 5'h11;
      7'h5B: glyph = 5'h12;
      7'h4F: glyph = 5'h13;
      7'h66: glyph = 5'h14;
      7'h6D: glyph = 5'h15;
      7'h7D: glyph = 5'h16;
      7'h07: glyph = 5'h17;
      7'h7F: glyph = 5'h18;
      7'h6F: glyph = 5'h19;
      7'h77: glyph = 5'h1A;
      7'h7C: glyph = 5'h1B;
      7'h39: glyph = 5'h1C;
      7'h5E: glyph = 5'h1D;
      7'h79: glyph = 5'h1E;
      7'h71: glyph = 5'h1F;
      default: glyph = 5'h00;
    endcase
  endfunction
  // cur = synchronized {clr, pen, do, clk}
  assign cur      = sync[SYNC_STAGES-1];
  assign clk_rise = cur[0] & ~prev[0];
  assign pen_rise = cur[2] & ~prev[1];
  // the bit on a coincident clk rise is shifted before the PEN count check
  assign n_sr  = clk_rise ? {sr[FRAME_BITS-2:0], cur[1]} : sr;
  assign n_cnt = (clk_rise && cnt != CW'(FRAME_BITS + 1)) ? cnt + CW'(1) : cnt;
  // segments are active-low; dp (bit 7) is never looked at
  assign g  = glyph(~stage[{idx, 3'b000} +: 7]);
  assign nd = {g[3:0], dig_acc};
  assign nv = {g[4], val_acc};
`ifdef SEG7_RX_SCORE_EN
  logic sc_ok;
  logic [10:0] sc_bin;
  assign sc_ok  = &nv[2:0] && nd[3:0] <= 4'd9 && nd[7:4] <= 4'd9 && nd[11:8] <= 4'd9;
  assign sc_bin = 11'(nd[11:8]) * 11'd100 + 11'(nd[7:4]) * 11'd10 + 11'(nd[3:0]);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync        <= '0;
      prev        <= '0;
      state       <= IDLE;
      sr          <= '0;
      stage       <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      idx         <= '0;
      dig_acc     <= '0;
      val_acc     <= '0;
      frame       <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SEG7_RX_SCORE_EN
      score_bin   <= '0;
      score_ok    <= 1'b0;
`endif
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], {seg_clr, seg_pen, seg_do, seg_clk}};
      prev        <= {cur[2], cur[0]};
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (state == DECODE) begin
        dig_acc <= nd[31:4];
        val_acc <= nv[7:1];
        idx     <= idx + 3'd1;
        if (idx == 3'd7) begin
          frame       <= stage;
          digits      <= nd;
          digit_valid <= nv;
          frame_valid <= 1'b1;
          state       <= IDLE;
          cnt         <= '0;
`ifdef SEG7_RX_SCORE_EN
          score_ok    <= sc_ok;
          if (sc_ok) score_bin <= sc_bin;
`endif
        end
      end else if (!cur[3]) begin
        sr    <= '0;
        cnt   <= '0;
        state <= IDLE;
      end else if (pen_rise) begin
        sr  <= '0;
        cnt <= '0;
        if (n_cnt == CW'(FRAME_BITS)) begin
          stage <= n_sr;
          idx   <= '0;
          state <= DECODE;
        end else begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end
      end else if (clk_rise) begin
        sr    <= n_sr;
        cnt   <= n_cnt;
        tcnt  <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          sr        <= '0;
          cnt       <= '0;
        end else tcnt <= tcnt + TW'(1);
      end
    end
  end
endmodule
